// File: rtl/hex_readback.sv
// hex_readback: scans HEX0..HEX(DIGITS-1) one digit per cycle and decodes the
// active-low seven-segment glyphs back to nibbles, flagging illegal patterns.
// Optional feature macro: HEX_READBACK_STABLE_EN (two matching captures per digit).
module hex_readback #(
    parameter int DIGITS = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [6:0]  hex0,
    input  logic [6:0]  hex1,
    input  logic [6:0]  hex2,
    input  logic [6:0]  hex3,
    input  logic [6:0]  hex4,
    input  logic [6:0]  hex5,
    output logic        busy,
    output logic        done,
    output logic [23:0] value,
    output logic [5:0]  valid_mask,
    output logic        error
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [2:0] LAST = 3'(DIGITS - 1);
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [23:0] value_q, value_d;
    logic [5:0]  mask_q, mask_d;
    logic [7:0][6:0] hex_bus;
    logic [6:0]  seg;
    logic [4:0]  dig;
    logic        cap;
`ifdef HEX_READBACK_STABLE_EN
    logic        ph_q, ph_d;
    logic [6:0]  first_q, first_d;
`endif
    // Unused mux slots read as blank so the 3-bit index never leaves the array.
    assign hex_bus = {{2{7'h7f}}, hex5, hex4, hex3, hex2, hex1, hex0};
    assign seg = hex_bus[idx_q];
    // Returns {legal, nibble}; anything outside the sixteen glyphs is illegal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0011000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction
    // Next-state and output computation for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        value_d = value_q;
        mask_d  = mask_q;
`ifdef HEX_READBACK_STABLE_EN
        ph_d    = ph_q;
        first_d = first_q;
        cap     = ph_q;
        dig     = (seg == first_q) ? decode(seg) : 5'h00;
`else
        cap     = 1'b1;
        dig     = decode(seg);
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                idx_d   = 3'd0;
                busy_d  = 1'b1;
                value_d = 24'h0;
                mask_d  = 6'h0;
                error_d = 1'b0;
`ifdef HEX_READBACK_STABLE_EN
                ph_d    = 1'b0;
`endif
            end
            SCAN: begin
`ifdef HEX_READBACK_STABLE_EN
                ph_d    = ~ph_q;
                first_d = seg;
`endif
                if (cap) begin
                    value_d[{idx_q, 2'b00} +: 4] = dig[3:0];
                    mask_d[idx_q] = dig[4];
                    if (idx_q == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        error_d = ~&mask_d[DIGITS-1:0];
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end
    // State register; reset aborts a scan with no done pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            value_q <= 24'h0;
            mask_q  <= 6'h0;
`ifdef HEX_READBACK_STABLE_EN
            ph_q    <= 1'b0;
            first_q <= 7'h0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            value_q <= value_d;
            mask_q  <= mask_d;
`ifdef HEX_READBACK_STABLE_EN
            ph_q    <= ph_d;
            first_q <= first_d;
`endif
        end
    end
    assign busy       = busy_q;
    assign done       = done_q;
    assign value      = value_q;
    assign valid_mask = mask_q;
    assign error      = error_q;
endmodule

// File: tb/tb_hex_readback.sv
// tb_hex_readback: directed bench with a result scoreboard for hex_readback
// (six-digit and two-digit instances).
module tb_hex_readback;
`ifdef HEX_READBACK_STABLE_EN
    localparam int M = 2;
`else
    localparam int M = 1;
`endif
    typedef struct packed {
        logic [23:0] value;
        logic [5:0]  mask;
        logic        err;
    } res_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [6:0]  hex [6];
    logic        busy, done, error, busy2, done2, error2;
    logic [23:0] value, value2;
    logic [5:0]  valid_mask, valid_mask2;
    logic        sel = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [23:0] o_value;
    logic [5:0]  o_mask;
    res_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    hex_readback dut (
        .clock(clock), .resetn(resetn), .start(start),
        .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]), .hex4(hex[4]), .hex5(hex[5]),
        .busy(busy), .done(done), .value(value), .valid_mask(valid_mask), .error(error)
    );
    hex_readback #(.DIGITS(2)) dut2 (
        .clock(clock), .resetn(resetn), .start(start2),
        .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]), .hex4(hex[4]), .hex5(hex[5]),
        .busy(busy2), .done(done2), .value(value2), .valid_mask(valid_mask2), .error(error2)
    );

    always #5 clock = ~clock;

    assign o_busy  = sel ? busy2 : busy;
    assign o_done  = sel ? done2 : done;
    assign o_err   = sel ? error2 : error;
    assign o_value = sel ? value2 : value;
    assign o_mask  = sel ? valid_mask2 : valid_mask;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_dec(input logic [6:0] s);
        for (int g = 0; g < 16; g++)
            if (glyph[g] == s) return {1'b1, 4'(g)};
        return 5'h00;
    endfunction

    // Pushes the predicted result, runs one scan, and checks it when done appears.
    // bp: tick at which a stray start is pulsed (0 = none); mut: tick after which hex1 becomes mv.
    task automatic run_scan(input bit two, input int bp, input int mut, input logic [6:0] mv);
        int   d;
        int   n;
        int   nb;
        bit   seen;
        res_t e;
        d    = two ? 2 : 6;
        n    = 0;
        nb   = 0;
        seen = 1'b0;
        e    = '0;
        sel  = two;
        for (int i = 0; i < d; i++) begin
            logic [6:0] a;
            logic [6:0] b;
            logic [4:0] r;
            int t1;
            int t2;
            t1 = M * i + 2;
            t2 = M * i + 1 + M;
            a = (i == 1 && mut != 0 && t1 > mut) ? mv : hex[i];
            b = (i == 1 && mut != 0 && t2 > mut) ? mv : hex[i];
            r = (a == b) ? model_dec(a) : 5'h00;
            e.value[4*i +: 4] = r[3:0];
            e.mask[i] = r[4];
        end
        e.err = (e.mask != 6'((1 << d) - 1));
        sb.push_back(e);
        if (two) start2 = 1'b1; else start = 1'b1;
        for (int t = 1; t <= 40 && !seen; t++) begin
            tick();
            if (two) start2 = (t == bp); else start = (t == bp);
            if (t == mut) hex[1] = mv;
            if (o_busy) nb++;
            if (o_done) begin
                seen = 1'b1;
                n = t;
            end
        end
        start  = 1'b0;
        start2 = 1'b0;
        chk("latency", n, M * d + 1);
        chk("busy_cycles", nb, M * d);
        chk("busy_low_in_done", o_busy, 1'b0);
        e = sb.pop_front();
        chk("value", o_value, e.value);
        chk("valid_mask", o_mask, e.mask);
        chk("error", o_err, e.err);
    endtask

    initial begin
        int cnt;
        // Reset held with start high: everything stays at reset values.
        for (int i = 0; i < 6; i++) hex[i] = 7'($urandom);
        start  = 1'b1;
        start2 = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_value", value, 24'h0);
        chk("rst_mask", valid_mask, 6'h0);
        chk("rst_error", error, 1'b0);
        chk("rst_value2", value2, 24'h0);
        start  = 1'b0;
        start2 = 1'b0;
        resetn = 1'b1;
        tick();
        // Legal scan 5,A,0,3,F,8.
        hex[0] = glyph[5]; hex[1] = glyph[10]; hex[2] = glyph[0];
        hex[3] = glyph[3]; hex[4] = glyph[15]; hex[5] = glyph[8];
        run_scan(1'b0, 0, 0, 7'h0);
        chk("legal_const_value", value, 24'h8F30A5);
        chk("legal_const_mask", valid_mask, 6'h3F);
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("value_held", value, 24'h8F30A5);
        // Blank digit on hex2 is illegal.
        for (int i = 0; i < 6; i++) hex[i] = glyph[1];
        hex[2] = 7'b1111111;
        run_scan(1'b0, 0, 0, 7'h0);
        chk("illegal_const_value", value, 24'h111011);
        chk("illegal_const_mask", valid_mask, 6'h3B);
        chk("illegal_const_error", error, 1'b1);
        repeat (2) tick();
        chk("error_held", error, 1'b1);
        // Two-digit instance; upper digits must stay untouched.
        hex[0] = glyph[9]; hex[1] = glyph[12];
        for (int i = 2; i < 6; i++) hex[i] = 7'b0101010;
        run_scan(1'b1, 0, 0, 7'h0);
        chk("d2_const_value", value2, 24'h0000C9);
        chk("d2_const_mask", valid_mask2, 6'h03);
        tick();
        // Reset two cycles into a scan aborts with no done pulse.
        for (int i = 0; i < 6; i++) hex[i] = glyph[4];
        sel   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_value", value, 24'h0);
        chk("abort_mask", valid_mask, 6'h0);
        chk("abort_error", error, 1'b0);
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (done) cnt++;
        end
        resetn = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        // A start pulsed while busy is ignored: exactly one done.
        run_scan(1'b0, 3, 0, 7'h0);
        cnt = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (done) cnt++;
        end
        chk("no_second_done", cnt, 0);
        // hex1 changes mid-scan: default build sees the new glyph at its capture edge,
        // stable build sees two differing captures and marks digit 1 illegal.
        for (int i = 0; i < 6; i++) hex[i] = glyph[2];
        run_scan(1'b0, 0, (M == 2) ? 4 : 2, glyph[7]);
`ifdef HEX_READBACK_STABLE_EN
        chk("stable_mask1", valid_mask[1], 1'b0);
        chk("stable_error", error, 1'b1);
`else
        chk("mut_const_value", value, 24'h222272);
        chk("mut_const_error", error, 1'b0);
`endif
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hex_readback.md
# hex_readback

Sequential segment-to-nibble reader for the six-digit seven-segment display path. On a start request it scans the active-low segment buses HEX0..HEX5 one digit per cycle, inverts the display encoding back to 4-bit values, and flags any pattern that is not a legal hex glyph. It sits beside the ALU display logic as the readback and self-check end of the display interface, so a bench or on-board checker can confirm what the display is showing.

## Interface
- DIGITS, default 6: number of digits scanned, starting at HEX0; legal range 1..6.
- clock  input  1  single clock; all state on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- hex0 .. hex5  input  7 each  active-low segment buses; bit 0 = a through bit 6 = g.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the scan completes.
- value  output  24  decoded nibbles; digit i occupies value[4i+3:4i].
- valid_mask  output  6  bit i = digit i held a legal glyph.
- error  output  1  high with done when any scanned digit is illegal; held until the next start.

## Operation
- Legal glyphs, written as g..a pattern -> nibble:
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F
- Any other pattern is illegal, including blank 1111111. An illegal digit gives nibble 0 and mask bit 0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: when start=1, clear value, valid_mask and error; set idx=0; go to SCAN.
  - SCAN: decode hex[idx] into its value slot and mask bit. If idx==DIGITS-1, go to DONE; otherwise idx+1.
  - DONE: done=1; error = ~&valid_mask[DIGITS-1:0]; go to IDLE.
- Digits at or above DIGITS are never written: their value bits and mask bits stay 0.
- start while busy or in DONE is ignored; it is not queued.
- value, valid_mask and error hold their last result in IDLE until the next accepted start.
- Inputs are assumed synchronous to clock; the block has no synchronizers.

## Timing
- Reset values: state IDLE, idx 0, busy 0, done 0, value 24'h0, valid_mask 6'h0, error 0.
- Reset mid-scan aborts immediately to the reset values; no done pulse is produced.
- Start accepted at edge k:
  - busy rises after edge k.
  - Digit i is captured at edge k+1+i.
  - DONE is entered after edge k+DIGITS; done and error are valid for that one cycle.
  - busy=0 during DONE.
- Latency from start to done pulse is DIGITS+1 cycles (7 for the default). A start held high through DONE re-arms on the first IDLE cycle.
- Segment inputs may change between digit captures. Each digit reflects its own capture edge.

## Configuration
- HEX_READBACK_STABLE_EN defined:
  - Each digit is captured on two consecutive edges (SCAN sub-phase 0, then 1).
  - If the two captures differ, the digit is illegal (nibble 0, mask 0).
  - Latency becomes 2*DIGITS+1 cycles (13 for the default).
- Undefined: single capture per digit, latency DIGITS+1.

## Test plan
- Reset: hold resetn=0 with start=1 -> all outputs at reset values. Release reset; pulse start -> done exactly 7 cycles later.
- Legal scan: hex0..hex5 = glyphs 5,A,0,3,F,8 -> value=24'h8F30A5, valid_mask=6'h3F, error=0, busy high for 6 cycles.
- Illegal digit: hex2=1111111, others glyph 1 -> value=24'h111011, valid_mask=6'h3B, error=1 with done.
- Parameter: DIGITS=2, hex0=glyph 9, hex1=glyph C -> value=24'h0000C9, valid_mask=6'h03, done after 3 cycles.
- Abort and re-start:
  - Assert resetn=0 two cycles into a scan -> no done pulse, outputs return to 0.
  - start pulsed while busy -> ignored, still exactly one done.
- HEX_READBACK_STABLE_EN: change hex1 between its two captures -> valid_mask[1]=0, error=1, done after 13 cycles.
